imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared encodings and field widths for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHK    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_LEN_HI = S_LEN_HI,
    ST_LEN_LO = S_LEN_LO,
    ST_DATA   = S_DATA,
    ST_WRITE  = S_WRITE,
    ST_CHK    = S_CHK,
    ST_DONE   = S_DONE,
    ST_ERR    = S_ERR
  } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian word assembly and running XOR of the data bytes.
// word presents the complete word including the byte being shifted in this cycle.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [1:0]        byte_idx,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_done,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] xor_acc
);

  logic [WORD_W-BYTE_W-1:0] word_q;
  logic [BYTE_W-1:0]        xor_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word_q <= '0;
      xor_q  <= '0;
    end else if (shift) begin
      word_q <= word[WORD_W-BYTE_W-1:0];
      xor_q  <= xor_q ^ byte_in;
    end
  end

  assign word      = {word_q, byte_in};
  assign word_done = shift && (byte_idx == 2'd3);
  assign xor_acc   = xor_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length header, big-endian words, XOR checksum.
// state  | meaning
// IDLE   | waiting for start after reset
// LEN_HI | expecting word-count high byte
// LEN_LO | expecting word-count low byte
// DATA   | collecting the 4 bytes of a word
// WRITE  | one-cycle memory write strobe
// CHK    | expecting checksum byte
// DONE   | image valid, core released
// ERR    | bad length or checksum, core held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_loaded
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] len_hi_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  words_q;
  logic [1:0]        idx_q;
  logic              accept, restart, shift, word_done;
  logic [WORD_W-1:0] word;
  logic [BYTE_W-1:0] xor_acc;
  logic [LEN_W-1:0]  len_in;

  assign byte_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign accept  = byte_valid && byte_ready;
  assign restart = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                             (state_q == ST_ERR));
  assign shift   = (state_q == ST_DATA) && accept;
  assign len_in  = {len_hi_q, byte_data};

  imem_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (restart),
    .shift     (shift),
    .byte_idx  (idx_q),
    .byte_in   (byte_data),
    .word_done (word_done),
    .word      (word),
    .xor_acc   (xor_acc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (restart) state_d = ST_LEN_HI;
      ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_in > MAX_LEN)   state_d = ST_ERR;
          else if (len_in == '0) state_d = ST_CHK;
          else                    state_d = ST_DATA;
        end
      end
      ST_DATA: if (word_done) state_d = ST_WRITE;
      ST_WRITE: begin
        if (({1'b0, words_q} + 17'd1) < {1'b0, len_q}) state_d = ST_DATA;
        else                                           state_d = ST_CHK;
      end
      ST_CHK: if (accept) state_d = (byte_data == xor_acc) ? ST_DONE : ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_hi_q  <= '0;
      len_q     <= '0;
      words_q   <= '0;
      idx_q     <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        words_q <= '0;
        idx_q   <= '0;
      end
      if ((state_q == ST_LEN_HI) && accept) len_hi_q <= byte_data;
      if ((state_q == ST_LEN_LO) && accept) len_q <= len_in;
      if (shift) idx_q <= idx_q + 2'd1;
      // Address and data are captured on the last byte so they are stable during WRITE.
      if (word_done) begin
        mem_addr  <= BASE_ADDR + {{(32-LEN_W-2){1'b0}}, words_q, 2'b00};
        mem_wdata <= word;
      end
      if ((state_q == ST_WRITE) && (words_q < len_q)) words_q <= words_q + 1'b1;
    end
  end

  assign mem_we       = (state_q == ST_WRITE);
  assign cpu_hold     = (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued, a monitor checks each strobe.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write actual=%h/%h required=no write", mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e[63:32]);
        chk("write_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$], input bit thr);
    int i = 0;
    int guard = 0;
    while (i < b.size() && guard < 2000) begin
      @(negedge clk);
      byte_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data = b[i];
      #1;
      if (byte_valid && byte_ready) i++;
      guard++;
    end
    if (i < b.size()) chk("send_timeout", 32'(i), 32'(b.size()));
    @(negedge clk) byte_valid = 1'b0;
  endtask

  task automatic push_nominal();
    exp_q.push_back({32'h0000_0000, 32'h2008_0005});
    exp_q.push_back({32'h0000_0004, 32'h2009_000A});
  endtask

  logic [7:0] nominal[$], badchk[$], oversize[$], zerolen[$], partial[$];

  initial begin
    nominal  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
    badchk   = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0F};
    oversize = '{8'h01, 8'h01};
    zerolen  = '{8'h00, 8'h00, 8'h00};
    partial  = '{8'h00, 8'h02, 8'h20, 8'h08};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);

    // nominal
    push_nominal();
    pulse_start();
    send(nominal, 1'b0);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_error", 32'(error), 32'd0);
    chk("nom_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("nom_words", 32'(words_loaded), 32'd2);
    chk("nom_pending", 32'(exp_q.size()), 32'd0);

    // bad checksum
    push_nominal();
    pulse_start();
    send(badchk, 1'b0);
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("bad_pending", 32'(exp_q.size()), 32'd0);

    // oversize length
    pulse_start();
    send(oversize, 1'b0);
    chk("ovs_error", 32'(error), 32'd1);
    chk("ovs_byte_ready", 32'(byte_ready), 32'd0);
    chk("ovs_words", 32'(words_loaded), 32'd0);

    // zero length
    pulse_start();
    send(zerolen, 1'b0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_words", 32'(words_loaded), 32'd0);

    // throttled source
    push_nominal();
    pulse_start();
    send(nominal, 1'b1);
    chk("thr_done", 32'(done), 32'd1);
    chk("thr_words", 32'(words_loaded), 32'd2);
    chk("thr_pending", 32'(exp_q.size()), 32'd0);

    // start while active is ignored, then reset mid-word
    pulse_start();
    send(partial, 1'b0);
    pulse_start();
    chk("mid_byte_ready", 32'(byte_ready), 32'd1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("mid_byte_ready_idle", 32'(byte_ready), 32'd0);
    chk("mid_mem_addr", mem_addr, 32'h0);
    chk("mid_mem_wdata", mem_wdata, 32'h0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_words", 32'(words_loaded), 32'd0);

    push_nominal();
    pulse_start();
    send(nominal, 1'b0);
    chk("fresh_done", 32'(done), 32'd1);
    chk("fresh_words", 32'(words_loaded), 32'd2);
    repeat (3) @(negedge clk);
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
